pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Pipeline sequencing controller for the five-stage R/I/J CPU. Decides every cycle whether the IF segment advances, stalls or redirects, and which pipeline registers receive bubbles. Handles load-use hazards, taken-branch redirection resolved in MEM, and multi-cycle instruction-fetch waits with a pending-redirect buffer and fetch timeout. Drives the `stall`, `cond` and `condNPC` inputs of the IF segment and the flush inputs of IF/ID, ID/EX and EX/MEM.

## Interface
- `WAIT_W`, 8: width of the fetch-wait counter.
- `WAIT_MAX`, 200: consecutive not-ready cycles that trigger the fetch error; must be less than 2^WAIT_W and at least 1.

- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `id_valid` in 1: ID stage holds a real instruction.
- `id_rs`, `id_rt` in 5: source registers of the ID instruction.
- `id_use_rs`, `id_use_rt` in 1: the ID instruction reads rs or rt.
- `ex_mem_read` in 1: the EX instruction is a load.
- `ex_wreg` in 5: destination register of the EX instruction.
- `br_taken` in 1: branch or jump in MEM is taken; one-cycle pulse.
- `br_target` in 32: redirect address, valid with `br_taken`.
- `imem_ready` in 1: instruction memory returns a valid IR this cycle.
- `if_stall` out 1: hold the PC; connects to IF `stall`.
- `if_cond` out 1: take the redirect; connects to IF `cond`.
- `if_condNPC` out 32: redirect address; connects to IF `condNPC`.
- `flush_id`, `flush_ex`, `flush_mem` out 1: load a bubble into IF/ID, ID/EX or EX/MEM.
- `id_hold` out 1: IF/ID keeps its contents.
- `fetch_err` out 1: sticky fetch timeout.
- `stall_cycles`, `flush_events` out 32: performance counters.

## Operation
- State machine with states RUN, WAIT and ERR. Internal registers: `pend` (1 bit), `pend_tgt` (32 bits), `wcnt` (WAIT_W bits).
- Load-use hazard (LU): `id_valid & ex_mem_read & ex_wreg!=0 & ((id_use_rs & id_rs==ex_wreg) | (id_use_rt & id_rt==ex_wreg))`.
- Branch flush: whenever `br_taken`=1, in any state, assert `flush_id`, `flush_ex` and `flush_mem` in that cycle.
- RUN:
  - `br_taken & imem_ready`: `if_cond`=1, `if_condNPC`=`br_target`, `if_stall`=0. Stay in RUN.
  - `br_taken & !imem_ready`: `if_stall`=1, `pend`<=1, `pend_tgt`<=`br_target`, `wcnt`<=1, go to WAIT.
  - LU without `br_taken`: `if_stall`=1, `id_hold`=1, `flush_ex`=1. Lasts one cycle by construction. Stay in RUN.
  - `!imem_ready` without `br_taken`: `if_stall`=1, `flush_id`=1, `wcnt`<=1, go to WAIT. LU is ignored while `flush_id` is asserted.
  - Otherwise all outputs are 0 and `if_condNPC`=0.
- WAIT:
  - `if_stall`=1 and `flush_id`=1 while `imem_ready`=0.
  - `br_taken`: `pend`<=1 and `pend_tgt`<=`br_target`. A newer branch overwrites an older one.
  - `imem_ready`=1 with `pend`=1 (or `br_taken`): `if_cond`=1, `if_condNPC`=`pend_tgt` (or `br_target` if `br_taken`), `flush_id`=1 to discard the wrong-path IR, `pend`<=0, go to RUN.
  - `imem_ready`=1 with `pend`=0: `if_stall`=0, go to RUN.
  - `imem_ready`=0: `wcnt`<=`wcnt`+1. When `wcnt`==WAIT_MAX, go to ERR.
- ERR: `if_stall`=1, `flush_id`=1, `fetch_err`=1. Leaves ERR only on `rst`.
- Priority: `br_taken` > fetch wait > LU.

## Timing
- All outputs except `fetch_err` and the counters are Mealy: combinational from state and inputs, 0-cycle latency.
- `fetch_err` is registered; it asserts in the cycle after `wcnt` reaches WAIT_MAX.
- A redirect is issued to IF no later than the first cycle `imem_ready`=1 after the branch.
- Reset values: state=RUN, `pend`=0, `pend_tgt`=0, `wcnt`=0, `fetch_err`=0, counters=0. All outputs are 0 while `rst`=1.
- Reset mid-WAIT discards any pending redirect.

## Configuration
- `PIPE_PERF_EN` defined:
  - `stall_cycles` increments every cycle `if_stall`=1.
  - `flush_events` increments every cycle any flush output is 1.
  - Both saturate at 0xFFFFFFFF and clear on `rst`.
- `PIPE_PERF_EN` undefined: no counter registers are built and both outputs are tied to 0.

## Test plan
- LU: `ex_mem_read`=1, `ex_wreg`=5, `id_rs`=5, `id_use_rs`=1, `id_valid`=1 -> one cycle of `if_stall`=`id_hold`=`flush_ex`=1. Repeat with `ex_wreg`=0 -> no stall.
- Branch in RUN: `br_taken`=1, `br_target`=0x40, `imem_ready`=1 -> same cycle `if_cond`=1, `if_condNPC`=0x40, all three flushes=1.
- Branch during wait: `imem_ready`=0 for 5 cycles, `br_taken` with target 0x80 in cycle 2 -> on the ready cycle `if_cond`=1, `if_condNPC`=0x80, `flush_id`=1, then RUN.
- Simultaneous branch and LU, target 0x10 -> `if_cond`=1, `if_stall`=0, `id_hold`=0.
- WAIT_MAX=4 with `imem_ready` held at 0 -> `fetch_err` rises after the 4th wait cycle and stays high. `rst` pulse -> `fetch_err`=0, state RUN.
- With `PIPE_PERF_EN`: 3 LU stalls plus 1 branch -> `stall_cycles`=3, `flush_events`=4. Without the macro -> both read 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: sequencing controller for the five-stage R/I/J pipeline.
// Every cycle it decides whether IF advances, stalls or redirects, and which
// pipeline registers take a bubble.
// Hazards handled: load-use stalls, taken-branch redirects resolved in MEM,
// and multi-cycle instruction-fetch waits.
// A branch that resolves while a fetch is outstanding is buffered, and the
// redirect is issued when the fetch completes.
// A fetch that stays not-ready for too long parks the controller in a sticky
// error state.
// Optional feature: define PIPE_PERF_EN to build the stall and flush
// performance counters; otherwise both counter outputs are tied to zero.
module pipe_hazard_ctrl #(
    parameter int WAIT_W   = 8,
    parameter int WAIT_MAX = 200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_use_rs,
    input  logic        id_use_rt,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_wreg,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        imem_ready,
    output logic        if_stall,
    output logic        if_cond,
    output logic [31:0] if_condNPC,
    output logic        flush_id,
    output logic        flush_ex,
    output logic        flush_mem,
    output logic        id_hold,
    output logic        fetch_err,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_events
);

    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_ERR  = 2'd2;

    localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(WAIT_MAX);
    localparam logic [WAIT_W-1:0] WCNT_ONE = WAIT_W'(1);

    // True when the ID instruction reads the register a load in EX is about to write.
    function automatic logic load_use(
        input logic       v,
        input logic       mr,
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic [4:0] wreg,
        input logic       urs,
        input logic       urt
    );
        return v & mr & (wreg != 5'd0) &
               ((urs & (rs == wreg)) | (urt & (rt == wreg)));
    endfunction

    logic [1:0]        state_r, state_n;
    logic              pend_r, pend_n;
    logic [31:0]       pend_tgt_r, tgt_n;
    logic [WAIT_W-1:0] wcnt_r, wcnt_n;
    logic              fetch_err_r, err_n;

    logic              lu_s;
    logic              stall_s, cond_s, fid_s, fex_s, fmem_s, hold_s;
    logic [31:0]       npc_s;

    assign lu_s = load_use(id_valid, ex_mem_read, id_rs, id_rt, ex_wreg,
                           id_use_rs, id_use_rt);

    // Next-state and Mealy output decode; priority is branch > fetch wait > load-use.
    always_comb begin
        state_n = state_r;
        pend_n  = pend_r;
        tgt_n   = pend_tgt_r;
        wcnt_n  = wcnt_r;
        err_n   = fetch_err_r;
        stall_s = 1'b0;
        cond_s  = 1'b0;
        npc_s   = 32'd0;
        fid_s   = 1'b0;
        fex_s   = 1'b0;
        fmem_s  = 1'b0;
        hold_s  = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (br_taken) begin
                    if (imem_ready) begin
                        cond_s = 1'b1;
                        npc_s  = br_target;
                    end else begin
                        // Fetch is outstanding: remember the target and redirect later.
                        stall_s = 1'b1;
                        pend_n  = 1'b1;
                        tgt_n   = br_target;
                        wcnt_n  = WCNT_ONE;
                        state_n = ST_WAIT;
                    end
                end else if (!imem_ready) begin
                    // The bubble in IF/ID also covers any load-use hazard this cycle.
                    stall_s = 1'b1;
                    fid_s   = 1'b1;
                    wcnt_n  = WCNT_ONE;
                    state_n = ST_WAIT;
                end else if (lu_s) begin
                    // The bubble in ID/EX clears the hazard, so this lasts one cycle.
                    stall_s = 1'b1;
                    hold_s  = 1'b1;
                    fex_s   = 1'b1;
                end else begin
                    stall_s = 1'b0;
                end
            end
            ST_WAIT: begin
                if (imem_ready) begin
                    state_n = ST_RUN;
                    pend_n  = 1'b0;
                    wcnt_n  = {WAIT_W{1'b0}};
                    if (br_taken) begin
                        cond_s = 1'b1;
                        npc_s  = br_target;
                        fid_s  = 1'b1;
                    end else if (pend_r) begin
                        // The IR that just arrived is wrong-path; drop it and redirect.
                        cond_s = 1'b1;
                        npc_s  = pend_tgt_r;
                        fid_s  = 1'b1;
                    end else begin
                        cond_s = 1'b0;
                    end
                end else begin
                    stall_s = 1'b1;
                    fid_s   = 1'b1;
                    if (br_taken) begin
                        // A newer branch overrides any older buffered target.
                        pend_n = 1'b1;
                        tgt_n  = br_target;
                    end else begin
                        pend_n = pend_r;
                    end
                    if (wcnt_r == WAIT_LIM) begin
                        state_n = ST_ERR;
                        err_n   = 1'b1;
                    end else begin
                        wcnt_n = wcnt_r + WCNT_ONE;
                    end
                end
            end
            ST_ERR: begin
                stall_s = 1'b1;
                fid_s   = 1'b1;
            end
            default: begin
                // An unreachable state encoding is treated as a fetch fault.
                stall_s = 1'b1;
                fid_s   = 1'b1;
                err_n   = 1'b1;
                state_n = ST_ERR;
            end
        endcase
        if (br_taken) begin
            fid_s  = 1'b1;
            fex_s  = 1'b1;
            fmem_s = 1'b1;
        end else begin
            fmem_s = 1'b0;
        end
    end

    // Controller state, pending-redirect buffer, wait counter and sticky error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_RUN;
            pend_r      <= 1'b0;
            pend_tgt_r  <= 32'd0;
            wcnt_r      <= {WAIT_W{1'b0}};
            fetch_err_r <= 1'b0;
        end else begin
            state_r     <= state_n;
            pend_r      <= pend_n;
            pend_tgt_r  <= tgt_n;
            wcnt_r      <= wcnt_n;
            fetch_err_r <= err_n;
        end
    end

    // Combinational outputs are forced quiet while reset is held.
    assign if_stall   = stall_s & ~rst;
    assign if_cond    = cond_s & ~rst;
    assign if_condNPC = rst ? 32'd0 : npc_s;
    assign flush_id   = fid_s & ~rst;
    assign flush_ex   = fex_s & ~rst;
    assign flush_mem  = fmem_s & ~rst;
    assign id_hold    = hold_s & ~rst;
    assign fetch_err  = fetch_err_r;

`ifdef PIPE_PERF_EN
    logic [31:0] stall_cnt_r;
    logic [31:0] flush_cnt_r;

    // Saturating counts of stall cycles and of cycles with any flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_r <= 32'd0;
            flush_cnt_r <= 32'd0;
        end else begin
            if (if_stall && (stall_cnt_r != 32'hFFFF_FFFF)) begin
                stall_cnt_r <= stall_cnt_r + 32'd1;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if ((flush_id || flush_ex || flush_mem) && (flush_cnt_r != 32'hFFFF_FFFF)) begin
                flush_cnt_r <= flush_cnt_r + 32'd1;
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

    assign stall_cycles = stall_cnt_r;
    assign flush_events = flush_cnt_r;
`else
    assign stall_cycles = 32'd0;
    assign flush_events = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl. A second instance with
// WAIT_MAX=4 exercises the fetch timeout under its own reset.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        rst4;
    logic        id_valid;
    logic [4:0]  id_rs, id_rt;
    logic        id_use_rs, id_use_rt;
    logic        ex_mem_read;
    logic [4:0]  ex_wreg;
    logic        br_taken;
    logic [31:0] br_target;
    logic        imem_ready;

    logic        if_stall, if_cond, flush_id, flush_ex, flush_mem, id_hold, fetch_err;
    logic [31:0] if_condNPC, stall_cycles, flush_events;

    logic        if_stall4, if_cond4, flush_id4, flush_ex4, flush_mem4, id_hold4, fetch_err4;
    logic [31:0] if_condNPC4, stall_cycles4, flush_events4;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ex_mem_read(ex_mem_read),
        .ex_wreg(ex_wreg), .br_taken(br_taken), .br_target(br_target),
        .imem_ready(imem_ready), .if_stall(if_stall), .if_cond(if_cond),
        .if_condNPC(if_condNPC), .flush_id(flush_id), .flush_ex(flush_ex),
        .flush_mem(flush_mem), .id_hold(id_hold), .fetch_err(fetch_err),
        .stall_cycles(stall_cycles), .flush_events(flush_events)
    );

    pipe_hazard_ctrl #(.WAIT_W(8), .WAIT_MAX(4)) dut4 (
        .clk(clk), .rst(rst4), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ex_mem_read(ex_mem_read),
        .ex_wreg(ex_wreg), .br_taken(br_taken), .br_target(br_target),
        .imem_ready(imem_ready), .if_stall(if_stall4), .if_cond(if_cond4),
        .if_condNPC(if_condNPC4), .flush_id(flush_id4), .flush_ex(flush_ex4),
        .flush_mem(flush_mem4), .id_hold(id_hold4), .fetch_err(fetch_err4),
        .stall_cycles(stall_cycles4), .flush_events(flush_events4)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        id_valid    = 1'b0;
        id_rs       = 5'd0;
        id_rt       = 5'd0;
        id_use_rs   = 1'b0;
        id_use_rt   = 1'b0;
        ex_mem_read = 1'b0;
        ex_wreg     = 5'd0;
        br_taken    = 1'b0;
        br_target   = 32'd0;
        imem_ready  = 1'b1;
    endtask

    // Move to the next negative edge with quiet inputs.
    task automatic tick();
        @(negedge clk);
        idle();
    endtask

    task automatic set_lu(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                          input logic urt, input logic [4:0] wreg);
        id_valid    = 1'b1;
        id_rs       = rs;
        id_rt       = rt;
        id_use_rs   = urs;
        id_use_rt   = urt;
        ex_mem_read = 1'b1;
        ex_wreg     = wreg;
    endtask

    function automatic logic [31:0] fl();
        return {29'd0, flush_id, flush_ex, flush_mem};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rst  = 1'b1;
        rst4 = 1'b1;
        br_taken  = 1'b1;
        br_target = 32'h40;
        #2;
        check_eq("rst_cond", {31'd0, if_cond}, 32'd0);
        check_eq("rst_npc", if_condNPC, 32'd0);
        check_eq("rst_flush", fl(), 32'd0);
        check_eq("rst_err", {31'd0, fetch_err}, 32'd0);
        check_eq("rst_cnt", stall_cycles | flush_events, 32'd0);

        tick(); rst = 1'b0; #1;
        check_eq("idle_stall", {31'd0, if_stall}, 32'd0);
        check_eq("idle_flush", fl(), 32'd0);

        // Three load-use stalls (rs, rt, rs), each one cycle.
        tick(); set_lu(5'd5, 5'd0, 1'b1, 1'b0, 5'd5); #1;
        check_eq("lu1_stall", {31'd0, if_stall}, 32'd1);
        check_eq("lu1_hold", {31'd0, id_hold}, 32'd1);
        check_eq("lu1_flush", fl(), 32'b010);
        tick(); #1;
        check_eq("lu1_after", {31'd0, if_stall}, 32'd0);
        tick(); set_lu(5'd0, 5'd7, 1'b0, 1'b1, 5'd7); #1;
        check_eq("lu2_stall", {31'd0, if_stall}, 32'd1);
        tick(); set_lu(5'd3, 5'd9, 1'b1, 1'b1, 5'd3); #1;
        check_eq("lu3_hold", {31'd0, id_hold}, 32'd1);
        tick(); set_lu(5'd0, 5'd0, 1'b1, 1'b0, 5'd0); #1;
        check_eq("lu_r0", {31'd0, if_stall}, 32'd0);
        tick(); set_lu(5'd5, 5'd0, 1'b0, 1'b0, 5'd5); #1;
        check_eq("lu_nouse", {31'd0, if_stall}, 32'd0);

        // Branch in RUN with the fetch ready: immediate redirect.
        tick(); br_taken = 1'b1; br_target = 32'h40; #1;
        check_eq("br_cond", {31'd0, if_cond}, 32'd1);
        check_eq("br_npc", if_condNPC, 32'h40);
        check_eq("br_flush", fl(), 32'b111);
        check_eq("br_stall", {31'd0, if_stall}, 32'd0);
        tick(); #1;
`ifdef PIPE_PERF_EN
        check_eq("perf_stall", stall_cycles, 32'd3);
        check_eq("perf_flush", flush_events, 32'd4);
`else
        check_eq("perf_stall", stall_cycles, 32'd0);
        check_eq("perf_flush", flush_events, 32'd0);
`endif

        // Branch together with a load-use hazard: branch wins.
        tick(); set_lu(5'd5, 5'd0, 1'b1, 1'b0, 5'd5); br_taken = 1'b1; br_target = 32'h10; #1;
        check_eq("brlu_cond", {31'd0, if_cond}, 32'd1);
        check_eq("brlu_npc", if_condNPC, 32'h10);
        check_eq("brlu_stall", {31'd0, if_stall}, 32'd0);
        check_eq("brlu_hold", {31'd0, id_hold}, 32'd0);

        // Five not-ready cycles, branch to 0x80 in the third.
        tick(); imem_ready = 1'b0; #1;
        check_eq("w_run_stall", {31'd0, if_stall}, 32'd1);
        check_eq("w_run_flush", fl(), 32'b100);
        tick(); imem_ready = 1'b0; #1;
        check_eq("w_wait_flush", fl(), 32'b100);
        tick(); imem_ready = 1'b0; br_taken = 1'b1; br_target = 32'h80; #1;
        check_eq("w_br_flush", fl(), 32'b111);
        check_eq("w_br_cond", {31'd0, if_cond}, 32'd0);
        tick(); imem_ready = 1'b0; #1;
        tick(); imem_ready = 1'b0; #1;
        check_eq("w_late_stall", {31'd0, if_stall}, 32'd1);
        tick(); #1;
        check_eq("w_rdy_cond", {31'd0, if_cond}, 32'd1);
        check_eq("w_rdy_npc", if_condNPC, 32'h80);
        check_eq("w_rdy_flush", fl(), 32'b100);
        check_eq("w_rdy_stall", {31'd0, if_stall}, 32'd0);
        tick(); #1;
        check_eq("w_back_run", {30'd0, if_cond, if_stall}, 32'd0);

        // Wait with nothing pending: plain resume.
        tick(); imem_ready = 1'b0; #1;
        tick(); #1;
        check_eq("wnp_cond", {31'd0, if_cond}, 32'd0);
        check_eq("wnp_flush", fl(), 32'd0);

        // Branch while fetch not ready, then a newer branch overwrites it.
        tick(); imem_ready = 1'b0; br_taken = 1'b1; br_target = 32'h100; #1;
        check_eq("pb_stall", {31'd0, if_stall}, 32'd1);
        check_eq("pb_cond", {31'd0, if_cond}, 32'd0);
        tick(); imem_ready = 1'b0; br_taken = 1'b1; br_target = 32'h200; #1;
        tick(); #1;
        check_eq("pb_npc", if_condNPC, 32'h200);
        check_eq("pb_cond2", {31'd0, if_cond}, 32'd1);

        // Branch arriving on the ready cycle of a wait.
        tick(); imem_ready = 1'b0; #1;
        tick(); br_taken = 1'b1; br_target = 32'h30; #1;
        check_eq("wbr_npc", if_condNPC, 32'h30);
        check_eq("wbr_flush", fl(), 32'b111);

        // Reset mid-wait drops the pending redirect.
        tick(); imem_ready = 1'b0; br_taken = 1'b1; br_target = 32'h55; #1;
        tick(); imem_ready = 1'b0; rst = 1'b1; #1;
        check_eq("rstw_stall", {31'd0, if_stall}, 32'd0);
        tick(); rst = 1'b0; #1;
        check_eq("rstw_cond", {31'd0, if_cond}, 32'd0);
        check_eq("rstw_npc", if_condNPC, 32'd0);

        // Fetch timeout on the WAIT_MAX=4 instance.
        tick(); rst4 = 1'b0; #1;
        for (int i = 0; i < 5; i++) begin
            tick(); imem_ready = 1'b0; #1;
            check_eq("to_noerr", {31'd0, fetch_err4}, 32'd0);
        end
        tick(); imem_ready = 1'b0; #1;
        check_eq("to_err", {31'd0, fetch_err4}, 32'd1);
        check_eq("to_err_stall", {30'd0, if_stall4, flush_id4}, 32'b11);
        tick(); #1;
        tick(); #1;
        check_eq("to_sticky", {31'd0, fetch_err4}, 32'd1);
        check_eq("to_sticky_stall", {31'd0, if_stall4}, 32'd1);
        tick(); rst4 = 1'b1; #1;
        check_eq("to_rst_err", {31'd0, fetch_err4}, 32'd0);
        tick(); rst4 = 1'b0; #1;
        check_eq("to_run_stall", {31'd0, if_stall4}, 32'd0);
        check_eq("to_run_err", {31'd0, fetch_err4}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
